multi_port_fifo: RTL and testbench
==================================

// Module: multi_port_fifo
//
// PURPOSE
// - Parametrised circular FIFO with N_PUSH write lanes and N_POP read lanes per cycle.
// - Serves wide front-ends, e.g. a fetch queue taking up to 2 instrs/cycle and a decode stage
//   draining up to 2 instrs/cycle.
// - Adds occupancy count, lane-valid outputs and guaranteed-space indication.
// - Read data is combinational from storage; write is registered.
//
// PARAMETERS
// - W       32  data width per entry
// - LG_D    3   log2 of depth; D = 1<<LG_D entries
// - N_PUSH  2   max entries written per cycle; 1 <= N_PUSH <= D
// - N_POP   2   max entries read per cycle; 1 <= N_POP <= D
//
// PORTS
// - clk        in   1                        clock
// - reset      in   1                        reset, synchronous, active-high
// - push_cnt   in   $clog2(N_PUSH+1)         entries written this cycle (0..N_PUSH)
// - in         in   N_PUSH*W                 lane i = in[i*W +: W]; lanes 0..push_cnt-1 written in order
// - pop_cnt    in   $clog2(N_POP+1)          entries removed this cycle (0..N_POP)
// - out        out  N_POP*W                  lane j = entry at head+j
// - out_valid  out  N_POP                    out_valid[j] = (j < count)
// - count      out  LG_D+1                   current occupancy, 0..D
// - empty      out  1                        count == 0
// - full       out  1                        count == D
// - space_ok   out  1                        (D - count) >= N_PUSH; a full-width push is legal
// - err        out  1                        sticky illegal-op flag (MPFIFO_ERR_CHK_EN only, else tied 0)
//
// BEHAVIOUR
// - Pointers rd_ptr/wr_ptr are LG_D+1 bits; the MSB is the wrap bit.
//   - count = wr_ptr - rd_ptr, modulo 2^(LG_D+1).
//   - Storage index = ptr[LG_D-1:0]; wrap-around is natural. Lanes wrap past D-1 to 0 within one cycle.
// - Reset: rd_ptr = wr_ptr = 0, err = 0. Hence count = 0, empty = 1, full = 0, space_ok = 1,
//   out_valid = 0. Storage contents are not reset; out data is don't-care while out_valid = 0.
// - Reset has priority over push/pop in the same cycle. Mid-operation reset discards all entries.
// - Push:
//   - At posedge, in lane i (i < push_cnt) goes to storage[wr_ptr+i].
//   - wr_ptr <= wr_ptr + push_cnt.
//   - Written data is visible on out the next cycle; there is no same-cycle bypass.
// - Pop:
//   - rd_ptr <= rd_ptr + pop_cnt.
//   - out lanes 0..pop_cnt-1 are the consumed entries, sampled combinationally this cycle.
// - Legality is judged against pre-edge state only. A simultaneous pop does not create space for
//   the same cycle's push, and a simultaneous push does not supply data to the same cycle's pop.
//   - Legal push: push_cnt <= D - count.
//   - Legal pop: pop_cnt <= count.
// - Simultaneous legal push and pop: both pointers advance; count_next = count + push_cnt - pop_cnt.
// - Full with push_cnt = 0 and pop_cnt = 0: state holds.
// - Empty: out_valid = 0; pop_cnt must be 0.
// - Latency: push to out_valid is 1 cycle. Pop to count update is 1 cycle.
// - All flags (empty, full, space_ok, count, out_valid) are combinational from registered pointers.
//
// CONFIGURATION
// - MPFIFO_ERR_CHK_EN defined:
//   - Illegal push (push_cnt > D - count): the whole push is dropped; wr_ptr and storage unchanged.
//   - Illegal pop (pop_cnt > count): the whole pop is dropped; rd_ptr unchanged.
//   - The legal half of a mixed request still executes.
//   - err is set the cycle after any illegal op and stays 1 until reset.
//   - Simulation prints an $error naming the offending counts.
// - MPFIFO_ERR_CHK_EN undefined:
//   - No checking logic; err is tied 0.
//   - Illegal ops yield undefined pointer and storage state.
//
// TESTING
// - T1 reset:
//   - Assert reset 2 cycles, then release.
//   - Expect count=0, empty=1, full=0, space_ok=1, out_valid=2'b00, err=0.
// - T2 dual push/pop, D=8:
//   - Push {0xA,0xB} (cnt 2), next cycle push {0xC} (cnt 1).
//   - Expect count=3, out={lane0=0xA, lane1=0xB}, out_valid=2'b11.
//   - Then pop 2: expect count=1, out lane0=0xC, out_valid=2'b01.
// - T3 fill and wrap:
//   - Push 2/cycle x4 -> full=1, space_ok=0.
//   - Pop 1 -> count=7, space_ok=0.
//   - Pop 1 -> count=6, space_ok=1.
//   - Continue push-2/pop-2 for 20 cycles; data order matches a scoreboard across the wrap.
// - T4 simultaneous push/pop:
//   - Start with count=3; apply push_cnt=2 and pop_cnt=2 together.
//   - Expect count stays 3 and the head advances by 2.
// - T5 illegal ops (ERR_CHK_EN):
//   - At count=7, push_cnt=2 -> push dropped, count stays 7, err=1 next cycle.
//   - At count=1, pop_cnt=2 -> pop dropped, err stays 1 until reset.
// - T6 reset mid-operation:
//   - Reset while count=5 with push_cnt=2 and pop_cnt=1 asserted.
//   - Expect count=0, empty=1 next cycle; the push is not stored.

Source files
------------

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: circular FIFO accepting up to N_PUSH entries and releasing
// up to N_POP entries per clock. Read data is combinational from storage, and
// writes are registered.
//
// Optional feature macro: MPFIFO_ERR_CHK_EN. When it is defined, an illegal
// push or pop is dropped and the sticky err flag is raised. When it is
// undefined, there is no checking logic and err is tied to 0.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; has priority over push/pop
//   push_cnt   entries written this cycle (0..N_PUSH), taken from lanes 0..push_cnt-1
//   in         N_PUSH lanes of W bits; lane i = in[i*W +: W]
//   pop_cnt    entries removed this cycle (0..N_POP)
//   out        N_POP lanes; lane j = entry at head+j
//   out_valid  out_valid[j] = (j < count)
//   count      occupancy, 0..D
//   empty      count == 0
//   full       count == D
//   space_ok   free space >= N_PUSH
//   err        sticky illegal-op flag (checking build only, else 0)
module multi_port_fifo #(
   parameter int W      = 32,
   parameter int LG_D   = 3,
   parameter int N_PUSH = 2,
   parameter int N_POP  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(N_PUSH+1)-1:0]   push_cnt,
   input  logic [N_PUSH*W-1:0]           in,
   input  logic [$clog2(N_POP+1)-1:0]    pop_cnt,
   output logic [N_POP*W-1:0]            out,
   output logic [N_POP-1:0]              out_valid,
   output logic [LG_D:0]                 count,
   output logic                          empty,
   output logic                          full,
   output logic                          space_ok,
   output logic                          err
);

   localparam int D = 1 << LG_D;
   localparam logic [LG_D:0] D_L = (LG_D+1)'(D);

   logic [LG_D:0]  rd_ptr_q, rd_ptr_d;
   logic [LG_D:0]  wr_ptr_q, wr_ptr_d;
   logic [W-1:0]   mem_q [D];
   logic [W-1:0]   mem_d [D];
   logic [LG_D:0]  free;
   logic           do_push;
   logic           do_pop;

   // The pointers carry one wrap bit, so their difference distinguishes full from empty.
   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      free     = D_L - count;
      empty    = (count == '0);
      full     = (count == D_L);
      space_ok = (free >= (LG_D+1)'(N_PUSH));
      for (int unsigned j = 0; j < N_POP; j++) begin
         out[j*W +: W] = mem_q[rd_ptr_q[LG_D-1:0] + LG_D'(j)];
         out_valid[j]  = (32'(count) > j);
      end
   end

`ifdef MPFIFO_ERR_CHK_EN
   logic push_legal;
   logic pop_legal;
   logic err_q, err_d;

   // Legality is judged only against the pre-edge occupancy.
   always_comb begin
      push_legal = ((LG_D+1)'(push_cnt) <= free);
      pop_legal  = ((LG_D+1)'(pop_cnt) <= count);
      do_push    = push_legal;
      do_pop     = pop_legal;
      err_d      = reset ? 1'b0 : (err_q | ~push_legal | ~pop_legal);
   end

   always_ff @(posedge clk) begin
      err_q <= err_d;
`ifndef SYNTHESIS
      if (!reset && (!push_legal || !pop_legal))
         $error("multi_port_fifo: illegal op push_cnt=%0d pop_cnt=%0d count=%0d",
                push_cnt, pop_cnt, count);
`endif
   end

   assign err = err_q;
`else
   always_comb begin
      do_push = 1'b1;
      do_pop  = 1'b1;
   end

   assign err = 1'b0;
`endif

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      mem_d    = mem_q;
      if (reset) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (do_pop)
            rd_ptr_d = rd_ptr_q + (LG_D+1)'(pop_cnt);
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + (LG_D+1)'(push_cnt);
            // Lane indices wrap naturally by truncating to LG_D bits.
            for (int unsigned i = 0; i < N_PUSH; i++) begin
               if (i < 32'(push_cnt))
                  mem_d[wr_ptr_q[LG_D-1:0] + LG_D'(i)] = in[i*W +: W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
   end

endmodule

// File: tb/tb_multi_port_fifo.sv
module tb_multi_port_fifo;

   localparam int W  = 32;
   localparam int D  = 8;
   localparam int NP = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      push_cnt = '0;
   logic [2*W-1:0]  in = '0;
   logic [1:0]      pop_cnt = '0;
   logic [2*W-1:0]  out;
   logic [1:0]      out_valid;
   logic [3:0]      count;
   logic            empty, full, space_ok, err;

   multi_port_fifo #(.W(W), .LG_D(3), .N_PUSH(2), .N_POP(2)) dut (
      .clk(clk), .reset(reset), .push_cnt(push_cnt), .in(in), .pop_cnt(pop_cnt),
      .out(out), .out_valid(out_valid), .count(count), .empty(empty), .full(full),
      .space_ok(space_ok), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model: a queue of entries plus a sticky error bit.
   logic [W-1:0] mq[$];
   bit           err_m = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         err_m = 1'b0;
      end else begin
         int  n;
         bit  lp, lq;
         n  = mq.size();
         lp = (int'(push_cnt) <= D - n);
         lq = (int'(pop_cnt) <= n);
`ifdef MPFIFO_ERR_CHK_EN
         if (!lp || !lq) err_m = 1'b1;
`endif
         if (lq) repeat (int'(pop_cnt)) void'(mq.pop_front());
         if (lp) for (int i = 0; i < int'(push_cnt); i++) mq.push_back(in[i*W +: W]);
      end
   end

   // Compare process: outputs reflect post-edge state, checked mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         logic [W-1:0] lane;
         n = mq.size();
         chk("count", 64'(count), 64'(n));
         chk("empty", 64'(empty), 64'(n == 0));
         chk("full", 64'(full), 64'(n == D));
         chk("space_ok", 64'(space_ok), 64'((D - n) >= NP));
         chk("out_valid", 64'(out_valid), 64'({n > 1, n > 0}));
         chk("err", 64'(err), 64'(err_m));
         for (int j = 0; j < 2; j++) begin
            if (j < n) begin
               lane = out[j*W +: W];
               chk("out_lane", 64'(lane), 64'(mq[j]));
            end
         end
      end
   end

   task automatic step(input int pc, input int pp, input bit r,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
      reset    = r;
      push_cnt = 2'(pc);
      pop_cnt  = 2'(pp);
      in       = {d1, d0};
      @(posedge clk);
      #1;
      reset    = 1'b0;
      push_cnt = '0;
      pop_cnt  = '0;
   endtask

   initial begin
      logic [W-1:0] l0, l1;
      int n, pc, pp;

      // T1 reset
      step(0, 0, 1'b1, '0, '0);
      step(0, 0, 1'b1, '0, '0);
      chk_en = 1'b1;
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_empty", 64'(empty), 64'd1);
      chk("t1_full", 64'(full), 64'd0);
      chk("t1_space_ok", 64'(space_ok), 64'd1);
      chk("t1_out_valid", 64'(out_valid), 64'd0);
      chk("t1_err", 64'(err), 64'd0);

      // T2 dual push then dual pop
      step(2, 0, 1'b0, 32'hA, 32'hB);
      step(1, 0, 1'b0, 32'hC, 32'h0);
      l0 = out[0 +: W];
      l1 = out[W +: W];
      chk("t2_count", 64'(count), 64'd3);
      chk("t2_lane0", 64'(l0), 64'hA);
      chk("t2_lane1", 64'(l1), 64'hB);
      chk("t2_valid", 64'(out_valid), 64'b11);
      step(0, 2, 1'b0, '0, '0);
      l0 = out[0 +: W];
      chk("t2_pop_count", 64'(count), 64'd1);
      chk("t2_pop_lane0", 64'(l0), 64'hC);
      chk("t2_pop_valid", 64'(out_valid), 64'b01);

      // T3 fill and wrap
      step(0, 1, 1'b0, '0, '0);
      repeat (4) step(2, 0, 1'b0, $urandom, $urandom);
      chk("t3_full", 64'(full), 64'd1);
      chk("t3_space_full", 64'(space_ok), 64'd0);
      step(0, 1, 1'b0, '0, '0);
      chk("t3_count7", 64'(count), 64'd7);
      chk("t3_space7", 64'(space_ok), 64'd0);
      step(0, 1, 1'b0, '0, '0);
      chk("t3_count6", 64'(count), 64'd6);
      chk("t3_space6", 64'(space_ok), 64'd1);
      repeat (20) step(2, 2, 1'b0, $urandom, $urandom);

      // T4 simultaneous push/pop at count 3
      repeat (3) step(0, 2, 1'b0, '0, '0);
      step(2, 0, 1'b0, 32'h31, 32'h32);
      step(1, 0, 1'b0, 32'h33, 32'h0);
      step(2, 2, 1'b0, 32'h34, 32'h35);
      l0 = out[0 +: W];
      l1 = out[W +: W];
      chk("t4_count", 64'(count), 64'd3);
      chk("t4_lane0", 64'(l0), 64'h33);
      chk("t4_lane1", 64'(l1), 64'h34);

`ifdef MPFIFO_ERR_CHK_EN
      // T5 illegal ops
      step(2, 0, 1'b0, $urandom, $urandom);
      step(2, 0, 1'b0, $urandom, $urandom);
      step(2, 0, 1'b0, $urandom, $urandom);
      chk("t5_push_drop_count", 64'(count), 64'd7);
      chk("t5_err_set", 64'(err), 64'd1);
      repeat (3) step(0, 2, 1'b0, '0, '0);
      step(0, 2, 1'b0, '0, '0);
      chk("t5_pop_drop_count", 64'(count), 64'd1);
      chk("t5_err_sticky", 64'(err), 64'd1);
`endif

      // T6 reset mid-operation
      while (mq.size() < 5) begin
         n = mq.size();
         step((5 - n) >= 2 ? 2 : 1, 0, 1'b0, $urandom, $urandom);
      end
      step(2, 1, 1'b1, 32'h55, 32'h66);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);
      chk("t6_err", 64'(err), 64'd0);
      step(1, 0, 1'b0, 32'h77, 32'h0);
      l0 = out[0 +: W];
      chk("t6_after_count", 64'(count), 64'd1);
      chk("t6_after_lane0", 64'(l0), 64'h77);
      chk("t6_after_valid", 64'(out_valid), 64'b01);

      // Randomized legal traffic with occasional resets
      repeat (400) begin
         n  = mq.size();
         pc = $urandom_range(0, (D - n) >= 2 ? 2 : D - n);
         pp = $urandom_range(0, n >= 2 ? 2 : n);
         step(pc, pp, ($urandom_range(0, 99) == 0), $urandom, $urandom);
      end

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
